// File: rtl/fetch_decode_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Supports a decode stall (hold) and a branch redirect that flushes IF/ID to a NOP bubble.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Stall,
    input  logic                 PCSrc,
    input  logic [31:0]          BranchTarget,
    output logic [31:0]          IMemAddr,
    input  logic [31:0]          IMemData,
    output logic [31:0]          Instruction,
    output logic [31:0]          PCPlus4,
    output logic                 ValidID,
    output logic [CNT_WIDTH-1:0] FetchCount
);

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    logic [31:0]          r_pc_p0;
    logic [31:0]          r_instr_p1;
    logic [31:0]          r_pcplus4_p1;
    logic                 r_vld_p1;
    logic [CNT_WIDTH-1:0] r_cnt_p1;
    logic [31:0]          w_pc_plus4_p0;

    assign w_pc_plus4_p0 = pc_inc(r_pc_p0);

    // Fetch (p0): PC register; memory address comes from the PC alone
    assign IMemAddr = r_pc_p0;

    // IF/ID (p1): redirect beats stall; PCPlus4 and FetchCount keep their values on a flush
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pc_p0      <= RESET_PC;
            r_instr_p1   <= NOP_INSTR;
            r_pcplus4_p1 <= 32'h0000_0000;
            r_vld_p1     <= 1'b0;
            r_cnt_p1     <= '0;
        end else if (PCSrc) begin
            r_pc_p0    <= word_align(BranchTarget);
            r_instr_p1 <= NOP_INSTR;
            r_vld_p1   <= 1'b0;
        end else if (!Stall) begin
            r_pc_p0      <= w_pc_plus4_p0;
            r_instr_p1   <= IMemData;
            r_pcplus4_p1 <= w_pc_plus4_p0;
            r_vld_p1     <= 1'b1;
            r_cnt_p1     <= r_cnt_p1 + CNT_WIDTH'(1);
        end
    end

    assign Instruction = r_instr_p1;
    assign PCPlus4     = r_pcplus4_p1;
    assign ValidID     = r_vld_p1;
    assign FetchCount  = r_cnt_p1;

endmodule
